// File: rtl/vend_coin_front_if.sv
// vend_coin_front_if
// Bundles the coin-side signals of the vending front end: the coin acceptor,
// keypad and cancel inputs, the request/response pair exchanged with the
// product-dispense FSM (total/seleccion out, listo/cambio back), and the
// payout/status outputs.
//
// Modports:
//   master - the coin front end (vend_coin_front): consumes coin/keypad/
//            dispense-FSM inputs, drives total/seleccion/coin_out/busy/no_credit.
//   slave  - the surrounding system (acceptor, keypad, dispense FSM).
interface vend_coin_front_if;
    logic       coin_vld;
    logic [1:0] coin_val;
    logic [1:0] sel_btn;
    logic       cancel;
    logic       listo;
    logic [1:0] cambio;
    logic [3:0] total;
    logic [1:0] seleccion;
    logic       coin_out;
    logic       busy;
    logic       no_credit;

    modport master (
        input  coin_vld, coin_val, sel_btn, cancel, listo, cambio,
        output total, seleccion, coin_out, busy, no_credit
    );

    modport slave (
        output coin_vld, coin_val, sel_btn, cancel, listo, cambio,
        input  total, seleccion, coin_out, busy, no_credit
    );
endinterface

// File: rtl/vend_coin_front.sv
// vend_coin_front
// Coin-side front end of the vending machine. Accumulates coins into a
// saturating 4-bit credit, presents credit and selection to the dispense FSM,
// waits for its listo/cambio answer, and pays change or a cancel refund as one
// coin_out pulse per unit, spaced PAY_GAP idle cycles apart.
//
// Ports:
//   clk  - clock
//   rst  - asynchronous, active-high reset
//   bus  - vend_coin_front_if.master:
//          in : coin_vld, coin_val[1:0], sel_btn[1:0], cancel, listo, cambio[1:0]
//          out: total[3:0], seleccion[1:0], coin_out, busy, no_credit
//
// Build option:
//   VEND_AUTO_REFUND_EN - when defined, a request timeout refunds the whole
//   retained credit through PAY instead of returning to IDLE with it.
//
// State | Meaning
// ------+---------------------------------------------------------------
// IDLE  | accepting coins, cancel and keypad requests
// REQ   | selection presented, waiting for listo or the timeout
// PAY   | emitting coin_out pulses until the pay count is exhausted
// COOL  | one cycle with seleccion=00 before returning to IDLE
module vend_coin_front #(
    parameter int MAX_CREDIT  = 15,
    parameter int REQ_TIMEOUT = 4,
    parameter int PAY_GAP     = 2
) (
    input  logic              clk,
    input  logic              rst,
    vend_coin_front_if.master bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_PAY  = 2'd2;
    localparam logic [1:0] ST_COOL = 2'd3;

    localparam int TO_W  = $clog2(REQ_TIMEOUT + 1);
    localparam int GAP_W = $clog2(PAY_GAP + 1);

    localparam logic [3:0]       MAX_C4  = 4'(MAX_CREDIT);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(REQ_TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LD  = GAP_W'(PAY_GAP);
    localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

    logic [1:0]       state_q, state_d;
    logic [3:0]       total_q, total_d;
    logic [1:0]       sel_q, sel_d;
    logic [3:0]       pay_q, pay_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic             coin_out_q, coin_out_d;
    logic             busy_q, busy_d;
    logic             no_credit_q, no_credit_d;

    logic [2:0] coin_amt;
    logic       coin_ok;
    logic       sel_valid;
    logic [4:0] sum5;
    logic [3:0] credit_add;

    always_comb begin
        coin_amt = 3'd0;
        case (bus.coin_val)
            2'b00:   coin_amt = 3'd1;
            2'b01:   coin_amt = 3'd2;
            2'b10:   coin_amt = 3'd5;
            default: coin_amt = 3'd0;
        endcase
    end

    assign coin_ok   = bus.coin_vld && (bus.coin_val != 2'b11);
    assign sel_valid = (bus.sel_btn == 2'b01) || (bus.sel_btn == 2'b10);

    // Add in 5 bits so a wrap past 15 can never look like a small credit.
    assign sum5       = {1'b0, total_q} + {2'b00, coin_amt};
    assign credit_add = (sum5 > {1'b0, MAX_C4}) ? MAX_C4 : sum5[3:0];

    always_comb begin
        state_d     = state_q;
        total_d     = total_q;
        sel_d       = sel_q;
        pay_d       = pay_q;
        gap_d       = gap_q;
        to_d        = to_q;
        coin_out_d  = 1'b0;
        no_credit_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // cancel consumes the cycle even at zero credit, so a coin or
                // keypad press arriving alongside it is dropped.
                if (bus.cancel) begin
                    if (total_q != 4'd0) begin
                        state_d = ST_PAY;
                        pay_d   = total_q;
                        total_d = 4'd0;
                        gap_d   = '0;
                    end
                end else if (sel_valid) begin
                    state_d = ST_REQ;
                    sel_d   = bus.sel_btn;
                    to_d    = '0;
                end else if (coin_ok) begin
                    total_d = credit_add;
                end
            end

            ST_REQ: begin
                // listo is checked first so it wins over a same-cycle expiry.
                if (bus.listo) begin
                    sel_d   = 2'b00;
                    total_d = 4'd0;
                    pay_d   = {2'b00, bus.cambio};
                    gap_d   = '0;
                    state_d = (bus.cambio != 2'b00) ? ST_PAY : ST_COOL;
                end else if (to_q == TO_LAST) begin
                    no_credit_d = 1'b1;
                    sel_d       = 2'b00;
`ifdef VEND_AUTO_REFUND_EN
                    if (total_q != 4'd0) begin
                        state_d = ST_PAY;
                        pay_d   = total_q;
                        total_d = 4'd0;
                        gap_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
`else
                    state_d = ST_IDLE;
`endif
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end

            ST_PAY: begin
                // gap_q counts the quiet cycles after each pulse; the exit to
                // COOL happens on the last gap cycle so no idle decision cycle
                // follows the final pulse.
                if (gap_q != '0) begin
                    gap_d = gap_q - GAP_ONE;
                    if ((gap_q == GAP_ONE) && (pay_q == 4'd0)) begin
                        state_d = ST_COOL;
                    end
                end else if (pay_q != 4'd0) begin
                    coin_out_d = 1'b1;
                    pay_d      = pay_q - 4'd1;
                    gap_d      = GAP_LD;
                end else begin
                    state_d = ST_COOL;
                end
            end

            ST_COOL: begin
                sel_d   = 2'b00;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                sel_d   = 2'b00;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            total_q     <= 4'd0;
            sel_q       <= 2'b00;
            pay_q       <= 4'd0;
            gap_q       <= '0;
            to_q        <= '0;
            coin_out_q  <= 1'b0;
            busy_q      <= 1'b0;
            no_credit_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            total_q     <= total_d;
            sel_q       <= sel_d;
            pay_q       <= pay_d;
            gap_q       <= gap_d;
            to_q        <= to_d;
            coin_out_q  <= coin_out_d;
            busy_q      <= busy_d;
            no_credit_q <= no_credit_d;
        end
    end

    assign bus.total     = total_q;
    assign bus.seleccion = sel_q;
    assign bus.coin_out  = coin_out_q;
    assign bus.busy      = busy_q;
    assign bus.no_credit = no_credit_q;

endmodule

// File: doc/vend_coin_front.md
Name: vend_coin_front

Overview:
- Coin-side front end of the vending machine. It accumulates inserted coins into a 4-bit credit and drives `total`/`seleccion` to the product-dispense FSM.
- It watches that FSM's `listo`/`cambio` response, then pays out change or a cancel refund as one `coin_out` pulse per credit unit.
- Sits between coin acceptor/keypad and the dispense FSM; it is the request/payout side of that `total`/`seleccion` → `listo`/`cambio` interface.

Parameters:
- MAX_CREDIT, 15, saturation ceiling for accumulated credit (≤15).
- REQ_TIMEOUT, 4, cycles to wait for `listo` before declaring "insufficient credit".
- PAY_GAP, 2, cycles between successive `coin_out` pulses (≥1).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- coin_vld  in  1  one-cycle strobe, coin accepted
- coin_val  in  2  coin value: 00=1, 01=2, 10=5, 11=invalid (ignored)
- sel_btn  in  2  keypad: 01=product A, 10=product B, 00/11 no request
- cancel  in  1  one-cycle strobe, refund request
- listo  in  1  dispense FSM: purchase accepted
- cambio  in  2  dispense FSM: change units, valid with `listo`
- total  out  4  current credit to dispense FSM
- seleccion  out  2  held selection to dispense FSM; 00 when not requesting
- coin_out  out  1  one-cycle pulse per unit paid out
- busy  out  1  high in any state except IDLE
- no_credit  out  1  one-cycle pulse on request timeout

Behaviour:
- Reset (async, any state): state=IDLE, `total`=0, `seleccion`=00, `coin_out`=0, `busy`=0, `no_credit`=0, all counters 0. Reset mid-payout abandons the remaining units.
- All outputs registered.
- States: IDLE, REQ, PAY, COOL.
- IDLE:
  - `coin_vld` with valid `coin_val` → `total` = min(`total` + value, MAX_CREDIT) next cycle. Overflow saturates; excess is lost.
  - `coin_val`=11 is ignored.
  - Precedence on the same cycle: `cancel` > `sel_btn` > coin.
  - `cancel` with `total`>0 → PAY, pay count = `total`, `total` cleared on entry.
  - `cancel` with `total`=0 → no action.
  - `sel_btn` ∈ {01,10} → REQ; `seleccion` = `sel_btn` next cycle; timeout counter cleared.
- REQ:
  - Coins and `cancel` ignored; `seleccion` and `total` held stable.
  - `listo`=1 → `seleccion`=00, `total`=0, pay count = `cambio`.
    - `cambio`>0 → PAY.
    - `cambio`=0 → COOL.
  - Timeout counter reaches REQ_TIMEOUT without `listo` → `no_credit` pulse, `seleccion`=00, `total` retained, → IDLE.
  - `listo` on the same cycle as the timeout expiry: `listo` wins.
- PAY:
  - Emit `coin_out` for 1 cycle, then low for PAY_GAP cycles; decrement pay count per pulse.
  - After the last pulse plus its gap → COOL. No pulse is ever emitted with pay count 0.
  - Inputs ignored.
- COOL:
  - One cycle with `seleccion`=00, guaranteeing the dispense FSM sees a deasserted selection → IDLE.
- `busy` = (state ≠ IDLE), registered alongside the state.
- Arithmetic: credit add done in 5 bits, then clamped to 4.
- `cambio` is 2-bit, so at most 3 change units. Any purchase credit beyond price+3 is forfeited by the interface; this is a documented limitation, not handled here.
- `listo` seen in IDLE/PAY/COOL is ignored.

Optional Feature:
- Macro: VEND_AUTO_REFUND_EN.
- Defined: REQ timeout refunds the full retained credit (→ PAY with pay count = `total`, `total`=0) instead of returning to IDLE with credit. `no_credit` still pulses.
- Undefined: timeout returns to IDLE with credit retained, as above.

Test Plan:
- Reset/accumulate: coins 1, 2, 5 → `total` = 1, 3, 8 on successive cycles; `coin_val`=11 leaves 8. Further coins 5, 5 → saturate at 15.
- Purchase with change: `total`=7, `sel_btn`=01, dispense FSM answers `listo`=1, `cambio`=2 → `seleccion`=01 held until `listo`, then exactly 2 `coin_out` pulses spaced PAY_GAP+1=3 cycles apart, COOL, IDLE, `total`=0.
- Exact payment: `total`=6, `sel_btn`=10, `listo`, `cambio`=0 → no `coin_out`, COOL one cycle, IDLE.
- Insufficient credit: `total`=3, `sel_btn`=01, no `listo` → `no_credit` pulse after 4 cycles, `total`=3, IDLE. With VEND_AUTO_REFUND_EN: 3 `coin_out` pulses, `total`=0.
- Cancel refund and precedence: `total`=5, `cancel` and `coin_vld` same cycle → coin ignored, 5 `coin_out` pulses. `cancel` at `total`=0 → nothing.
- Reset mid-PAY after 1 of 4 pulses → all outputs 0 immediately, no further `coin_out`.
